sprite_line_culler: RTL

- Per-scanline consumer of the transformed sprite table written by the sprite transform pre-pass. Reads the 120-bit transformed entries through the table's read port.
- On each `start`, walks all SPRITE_COUNT entries for one screen row and keeps only the sprites that cover that row and are on screen.
- Streams the kept sprites to the sprite column renderer over a valid/ready interface.

---
 rtl/sprite_line_culler.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_culler.sv
// Per-scanline sprite culler: scans the transformed sprite table for one row and streams visible sprites.
// Optional build macro SPRITE_CULL_SORT_EN keeps the line buffer sorted far-to-near by depth.
module sprite_line_culler #(
    parameter int SPRITE_COUNT = 128,
    parameter int MAX_PER_LINE = 8,
    parameter int WIDTH        = 320,
    parameter int HEIGHT       = 240,
    localparam int AW = $clog2(SPRITE_COUNT),
    localparam int CW = $clog2(MAX_PER_LINE + 1),
    localparam int RW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    line,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] stmeta_raddr,
    input  logic [119:0]  stmeta_read_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_id,
    output logic [7:0]    out_tex,
    output logic [15:0]   out_depth,
    output logic [15:0]   out_screenx,
    output logic [15:0]   out_height,
    output logic [15:0]   out_startx,
    output logic [15:0]   out_endx,
    output logic          out_last,
    output logic          overflow
);

    // state   | meaning
    // S_IDLE  | waiting for start, table address parked at 0
    // S_SCAN  | issuing table addresses, evaluating the previous entry
    // S_DRAIN | presenting buffered entries over valid/ready
    // S_DONE  | one-cycle done pulse, start ignored

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [AW-1:0] id;
        logic [7:0]    tex;
        logic [15:0]   depth;
        logic [15:0]   screenx;
        logic [15:0]   height;
        logic [15:0]   startx;
        logic [15:0]   endx;
    } ent_t;

    localparam logic [AW:0]          SCAN_LAST = (AW + 1)'(SPRITE_COUNT);
    localparam logic [CW-1:0]        CNT_FULL  = CW'(MAX_PER_LINE);
    localparam logic signed [15:0]   X_MAX     = 16'(WIDTH - 1);
    localparam logic [8:0]           LINE_END  = 9'(HEIGHT);

    state_t        state_q, state_d;
    logic [AW:0]   scan_cnt;
    logic [7:0]    line_q;
    logic [CW-1:0] count, count_d;
    logic [RW-1:0] rd_idx;
    logic          drop;
    logic          hit;
    logic          eval_en;
    logic          line_on_screen;
    logic          full;
    logic          last_scan;
    logic          drain_last;
    ent_t          new_ent;
    ent_t          out_ent;
    ent_t          slot_q [MAX_PER_LINE];
    ent_t          slot_d [MAX_PER_LINE];

    logic signed [15:0] f_depth, f_starty, f_endy, f_startx, f_endx, line_s;

    assign f_depth  = stmeta_read_data[111:96];
    assign f_starty = stmeta_read_data[63:48];
    assign f_endy   = stmeta_read_data[47:32];
    assign f_startx = stmeta_read_data[31:16];
    assign f_endx   = stmeta_read_data[15:0];
    assign line_s   = {8'd0, line_q};

    // scan_cnt==0 only issues address 0; data for entry scan_cnt-1 is on the bus
    assign eval_en        = (state_q == S_SCAN) && (scan_cnt != '0);
    // rows below the screen cannot show anything
    assign line_on_screen = ({1'b0, line_q} < LINE_END);

    assign hit = eval_en && line_on_screen
                 && (f_depth > 16'sd0)
                 && (f_starty <= line_s) && (line_s <= f_endy)
                 && (f_endx >= 16'sd0)
                 && (f_startx <= X_MAX)
                 && (f_startx <= f_endx);

    assign full       = (count == CNT_FULL);
    assign last_scan  = (scan_cnt == SCAN_LAST);
    assign drain_last = (CW'(rd_idx) == count - CW'(1));

    always_comb begin
        new_ent         = '0;
        new_ent.id      = scan_cnt[AW-1:0] - AW'(1);
        new_ent.tex     = stmeta_read_data[119:112];
        new_ent.depth   = f_depth;
        new_ent.screenx = stmeta_read_data[95:80];
        new_ent.height  = stmeta_read_data[79:64];
        new_ent.startx  = (f_startx < 16'sd0) ? 16'd0 : f_startx;
        new_ent.endx    = (f_endx > X_MAX) ? X_MAX : f_endx;
    end

`ifdef SPRITE_CULL_SORT_EN
    logic [CW-1:0] pos;
    logic          nearer;
`endif

    // Next buffer contents and count for the entry under evaluation
    always_comb begin
        slot_d  = slot_q;
        count_d = count;
        drop    = 1'b0;
`ifdef SPRITE_CULL_SORT_EN
        // buffer is sorted descending, so entries at least as far form a prefix
        pos = '0;
        for (int j = 0; j < MAX_PER_LINE; j++) begin
            if ((CW'(j) < count) && ($signed(slot_q[j].depth) >= $signed(new_ent.depth)))
                pos = pos + CW'(1);
        end
        nearer = ($signed(new_ent.depth) < $signed(slot_q[0].depth));
`endif
        if (hit) begin
            if (!full) begin
                count_d = count + CW'(1);
`ifdef SPRITE_CULL_SORT_EN
                for (int j = 0; j < MAX_PER_LINE; j++) begin
                    if (CW'(j) == pos)
                        slot_d[j] = new_ent;
                    else if (CW'(j) > pos)
                        slot_d[j] = slot_q[(j + MAX_PER_LINE - 1) % MAX_PER_LINE];
                end
`else
                for (int j = 0; j < MAX_PER_LINE; j++) begin
                    if (CW'(j) == count)
                        slot_d[j] = new_ent;
                end
`endif
            end else begin
                drop = 1'b1;
`ifdef SPRITE_CULL_SORT_EN
                // evict the farthest (slot 0) and slide the farther prefix down by one
                if (nearer) begin
                    for (int j = 0; j < MAX_PER_LINE; j++) begin
                        if (CW'(j) + CW'(1) < pos)
                            slot_d[j] = slot_q[(j + 1) % MAX_PER_LINE];
                        else if (CW'(j) + CW'(1) == pos)
                            slot_d[j] = new_ent;
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            scan_cnt <= '0;
            line_q   <= '0;
            count    <= '0;
            rd_idx   <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        line_q   <= line;
                        count    <= '0;
                        overflow <= 1'b0;
                        scan_cnt <= '0;
                        rd_idx   <= '0;
                    end
                end
                S_SCAN: begin
                    scan_cnt <= scan_cnt + (AW + 1)'(1);
                    count    <= count_d;
                    if (drop)
                        overflow <= 1'b1;
                end
                S_DRAIN: begin
                    if (out_ready && !drain_last)
                        rd_idx <= rd_idx + RW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_SCAN))
            slot_q <= slot_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SCAN;
            S_SCAN:  if (last_scan) state_d = (count_d == '0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (out_ready && drain_last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == S_SCAN) || (state_q == S_DRAIN);
        done         = (state_q == S_DONE);
        out_valid    = (state_q == S_DRAIN);
        out_last     = (state_q == S_DRAIN) && drain_last;
        stmeta_raddr = (state_q == S_SCAN) ? scan_cnt[AW-1:0] : '0;
        out_ent      = '0;
        if (state_q == S_DRAIN)
            out_ent = slot_q[rd_idx];
    end

    assign out_id      = out_ent.id;
    assign out_tex     = out_ent.tex;
    assign out_depth   = out_ent.depth;
    assign out_screenx = out_ent.screenx;
    assign out_height  = out_ent.height;
    assign out_startx  = out_ent.startx;
    assign out_endx    = out_ent.endx;

endmodule
